id_ex_operand_stage: RTL and testbench

- ID/EX pipeline register directly downstream of the register file.
- Captures register-file read data PA/PB addressed by RA/RB, together with the decoded destination and control bits.
- Before latching, resolves data hazards by forwarding from the EX, MEM and WB stages.
- Detects load-use hazards, asserts Stall to freeze IF/ID, and inserts a one-cycle bubble.

---
 rtl/id_ex_operand_stage.sv | 163 ++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand register: captures register-file operands with EX/MEM/WB
// forwarding, and inserts a one-cycle bubble on load-use hazards or flush.
module id_ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [DATA_W-1:0] PA,
    input  logic [DATA_W-1:0] PB,
    input  logic              ID_VALID,
    input  logic              ID_USE_A,
    input  logic              ID_USE_B,
    input  logic [ADDR_W-1:0] ID_RD,
    input  logic              ID_WE,
    input  logic              ID_LOAD,
    input  logic [DATA_W-1:0] EX_RES,
    input  logic [ADDR_W-1:0] MEM_RD,
    input  logic              MEM_WE,
    input  logic [DATA_W-1:0] MEM_RES,
    input  logic [ADDR_W-1:0] RW,
    input  logic              LE,
    input  logic [DATA_W-1:0] PW,
    input  logic              Flush,
    output logic [DATA_W-1:0] Q_A,
    output logic [DATA_W-1:0] Q_B,
    output logic [ADDR_W-1:0] Q_RD,
    output logic              Q_WE,
    output logic              Q_LOAD,
    output logic              Q_VALID,
    output logic              Stall,
    output logic [1:0]        FWD_A,
    output logic [1:0]        FWD_B
);

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;
    localparam logic [1:0] SEL_EX  = 2'd3;

    logic [DATA_W-1:0] q_a_r;
    logic [DATA_W-1:0] q_b_r;
    logic [ADDR_W-1:0] q_rd_r;
    logic              q_we_r;
    logic              q_load_r;
    logic              q_valid_r;

    logic              ex_fwd_ok_s;
    logic [1:0]        fwd_a_s;
    logic [1:0]        fwd_b_s;
    logic [DATA_W-1:0] op_a_s;
    logic [DATA_W-1:0] op_b_s;
    logic              hazard_a_s;
    logic              hazard_b_s;
    logic              stall_s;
    logic              bubble_s;

    // GR0 is never matched; otherwise the youngest writer wins.
    function automatic logic [1:0] fwd_sel(
        input logic [ADDR_W-1:0] src,
        input logic              ex_ok,
        input logic [ADDR_W-1:0] ex_rd,
        input logic              mem_we,
        input logic [ADDR_W-1:0] mem_rd,
        input logic              wb_we,
        input logic [ADDR_W-1:0] wb_rd
    );
        logic [1:0] sel;
        if (src == {ADDR_W{1'b0}}) begin
            sel = SEL_RF;
        end else if (ex_ok && (ex_rd == src)) begin
            sel = SEL_EX;
        end else if (mem_we && (mem_rd == src)) begin
            sel = SEL_MEM;
        end else if (wb_we && (wb_rd == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_mux(
        input logic [ADDR_W-1:0] src,
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] wb,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] ex
    );
        logic [DATA_W-1:0] val;
        if (src == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else begin
            case (sel)
                SEL_RF:  val = rf;
                SEL_WB:  val = wb;
                SEL_MEM: val = mem;
                SEL_EX:  val = ex;
                default: val = rf;
            endcase
        end
        return val;
    endfunction

    // Forwarding selects and operand muxes.
    always_comb begin
        // A load in EX has no result yet, so it cannot forward from EX.
        ex_fwd_ok_s = q_valid_r & q_we_r & ~q_load_r;
        fwd_a_s = fwd_sel(RA, ex_fwd_ok_s, q_rd_r, MEM_WE, MEM_RD, LE, RW);
        fwd_b_s = fwd_sel(RB, ex_fwd_ok_s, q_rd_r, MEM_WE, MEM_RD, LE, RW);
        op_a_s  = fwd_mux(RA, fwd_a_s, PA, PW, MEM_RES, EX_RES);
        op_b_s  = fwd_mux(RB, fwd_b_s, PB, PW, MEM_RES, EX_RES);
    end

    // Load-use hazard detection; flush suppresses the stall.
    always_comb begin
        hazard_a_s = ID_USE_A & (RA != {ADDR_W{1'b0}}) & (RA == q_rd_r);
        hazard_b_s = ID_USE_B & (RB != {ADDR_W{1'b0}}) & (RB == q_rd_r);
        stall_s    = ID_VALID & q_valid_r & q_load_r & q_we_r & ~Flush &
                     (hazard_a_s | hazard_b_s);
        bubble_s   = Flush | stall_s;
    end

    // Pipeline register: reset, bubble, or latch the forwarded operands.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            q_a_r     <= {DATA_W{1'b0}};
            q_b_r     <= {DATA_W{1'b0}};
            q_rd_r    <= {ADDR_W{1'b0}};
            q_we_r    <= 1'b0;
            q_load_r  <= 1'b0;
            q_valid_r <= 1'b0;
        end else if (bubble_s) begin
            q_a_r     <= {DATA_W{1'b0}};
            q_b_r     <= {DATA_W{1'b0}};
            q_rd_r    <= {ADDR_W{1'b0}};
            q_we_r    <= 1'b0;
            q_load_r  <= 1'b0;
            q_valid_r <= 1'b0;
        end else begin
            q_a_r     <= op_a_s;
            q_b_r     <= op_b_s;
            q_rd_r    <= ID_VALID ? ID_RD : {ADDR_W{1'b0}};
            q_we_r    <= ID_VALID & ID_WE;
            q_load_r  <= ID_VALID & ID_LOAD;
            q_valid_r <= ID_VALID;
        end
    end

    assign Q_A     = q_a_r;
    assign Q_B     = q_b_r;
    assign Q_RD    = q_rd_r;
    assign Q_WE    = q_we_r;
    assign Q_LOAD  = q_load_r;
    assign Q_VALID = q_valid_r;
    assign Stall   = stall_s;
    assign FWD_A   = fwd_a_s;
    assign FWD_B   = fwd_b_s;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: reset, forwarding priority,
// load-use stall, GR0 handling, flush and reset interaction.
module tb_id_ex_operand_stage;

    logic        Clk;
    logic        Rst_n;
    logic [4:0]  RA, RB, ID_RD, MEM_RD, RW;
    logic [31:0] PA, PB, EX_RES, MEM_RES, PW;
    logic        ID_VALID, ID_USE_A, ID_USE_B, ID_WE, ID_LOAD, MEM_WE, LE, Flush;
    logic [31:0] Q_A, Q_B;
    logic [4:0]  Q_RD;
    logic        Q_WE, Q_LOAD, Q_VALID, Stall;
    logic [1:0]  FWD_A, FWD_B;

    int errors = 0;
    int checks = 0;

    id_ex_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .PA(PA), .PB(PB),
        .ID_VALID(ID_VALID), .ID_USE_A(ID_USE_A), .ID_USE_B(ID_USE_B),
        .ID_RD(ID_RD), .ID_WE(ID_WE), .ID_LOAD(ID_LOAD), .EX_RES(EX_RES),
        .MEM_RD(MEM_RD), .MEM_WE(MEM_WE), .MEM_RES(MEM_RES),
        .RW(RW), .LE(LE), .PW(PW), .Flush(Flush),
        .Q_A(Q_A), .Q_B(Q_B), .Q_RD(Q_RD), .Q_WE(Q_WE), .Q_LOAD(Q_LOAD),
        .Q_VALID(Q_VALID), .Stall(Stall), .FWD_A(FWD_A), .FWD_B(FWD_B)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic idle();
        Rst_n = 1'b1; RA = 5'd0; RB = 5'd0; PA = 32'd0; PB = 32'd0;
        ID_VALID = 1'b0; ID_USE_A = 1'b0; ID_USE_B = 1'b0;
        ID_RD = 5'd0; ID_WE = 1'b0; ID_LOAD = 1'b0; EX_RES = 32'd0;
        MEM_RD = 5'd0; MEM_WE = 1'b0; MEM_RES = 32'd0;
        RW = 5'd0; LE = 1'b0; PW = 32'd0; Flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        Rst_n = 1'b0; ID_VALID = 1'b1; PA = 32'd5; RA = 5'd3;
        ID_RD = 5'd3; ID_WE = 1'b1; ID_LOAD = 1'b1;
        tick(); tick();
        checks++;
        if ({Q_A, Q_B, Q_RD, Q_WE, Q_LOAD, Q_VALID} !== 72'd0) begin
            errors++;
            $display("FAIL reset_q: got A=%h B=%h RD=%0d WE=%b LD=%b V=%b, expected all 0",
                     Q_A, Q_B, Q_RD, Q_WE, Q_LOAD, Q_VALID);
        end
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", Stall);
        end
        Rst_n = 1'b1; PA = 32'h11; ID_WE = 1'b0; ID_LOAD = 1'b0; ID_RD = 5'd0;
        tick();
        checks++;
        if (Q_A !== 32'h11 || Q_VALID !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got A=%h V=%b expected A=00000011 V=1", Q_A, Q_VALID);
        end
    endtask

    task automatic test_ex_forward();
        idle();
        ID_VALID = 1'b1; ID_RD = 5'd4; ID_WE = 1'b1;
        tick();
        RA = 5'd4; PA = 32'd0; EX_RES = 32'h2A; ID_RD = 5'd5;
        #1;
        checks++;
        if (FWD_A !== 2'd3) begin
            errors++; $display("FAIL ex_fwd_sel: got %0d expected 3", FWD_A);
        end
        tick();
        checks++;
        if (Q_A !== 32'h2A || Q_RD !== 5'd5) begin
            errors++;
            $display("FAIL ex_fwd_data: got A=%h RD=%0d expected A=0000002a RD=5", Q_A, Q_RD);
        end
    endtask

    task automatic test_priority();
        idle();
        ID_VALID = 1'b1; RA = 5'd7; RB = 5'd7;
        MEM_WE = 1'b1; MEM_RD = 5'd7; MEM_RES = 32'h100;
        LE = 1'b1; RW = 5'd7; PW = 32'h200; PA = 32'h300; PB = 32'h400;
        #1;
        checks++;
        if (FWD_A !== 2'd2) begin
            errors++; $display("FAIL prio_mem_sel: got %0d expected 2", FWD_A);
        end
        tick();
        checks++;
        if (Q_A !== 32'h100) begin
            errors++; $display("FAIL prio_mem_data: got %h expected 00000100", Q_A);
        end
        MEM_WE = 1'b0;
        #1;
        checks++;
        if (FWD_B !== 2'd1) begin
            errors++; $display("FAIL prio_wb_sel: got %0d expected 1", FWD_B);
        end
        tick();
        checks++;
        if (Q_A !== 32'h200) begin
            errors++; $display("FAIL prio_wb_data: got %h expected 00000200", Q_A);
        end
        LE = 1'b0;
        tick();
        checks++;
        if (Q_A !== 32'h300 || Q_B !== 32'h400) begin
            errors++;
            $display("FAIL prio_rf_data: got A=%h B=%h expected 00000300 00000400", Q_A, Q_B);
        end
    endtask

    task automatic test_load_use();
        idle();
        ID_VALID = 1'b1; ID_LOAD = 1'b1; ID_WE = 1'b1; ID_RD = 5'd9;
        tick();
        ID_LOAD = 1'b0; ID_RD = 5'd10; RB = 5'd9; ID_USE_B = 1'b1; PB = 32'd0;
        #1;
        checks++;
        if (Stall !== 1'b1 || FWD_B !== 2'd0) begin
            errors++;
            $display("FAIL lu_stall: got Stall=%b FWD_B=%0d expected 1 and 0", Stall, FWD_B);
        end
        tick();
        checks++;
        if (Q_VALID !== 1'b0 || Q_LOAD !== 1'b0 || Q_WE !== 1'b0) begin
            errors++;
            $display("FAIL lu_bubble: got V=%b LD=%b WE=%b expected 0 0 0", Q_VALID, Q_LOAD, Q_WE);
        end
        MEM_WE = 1'b1; MEM_RD = 5'd9; MEM_RES = 32'hDEAD;
        #1;
        checks++;
        if (Stall !== 1'b0 || FWD_B !== 2'd2) begin
            errors++;
            $display("FAIL lu_release: got Stall=%b FWD_B=%0d expected 0 and 2", Stall, FWD_B);
        end
        tick();
        checks++;
        if (Q_B !== 32'hDEAD || Q_VALID !== 1'b1 || Q_RD !== 5'd10) begin
            errors++;
            $display("FAIL lu_mem_data: got B=%h V=%b RD=%0d expected 0000dead 1 10", Q_B, Q_VALID, Q_RD);
        end
    endtask

    task automatic test_gr0_and_unused();
        idle();
        ID_VALID = 1'b1; ID_WE = 1'b1; ID_RD = 5'd0;
        tick();
        EX_RES = 32'hFF; MEM_WE = 1'b1; MEM_RD = 5'd0; MEM_RES = 32'hFF;
        LE = 1'b1; RW = 5'd0; PW = 32'hFF; PA = 32'hFF; ID_WE = 1'b0;
        #1;
        checks++;
        if (FWD_A !== 2'd0) begin
            errors++; $display("FAIL gr0_sel: got %0d expected 0", FWD_A);
        end
        tick();
        checks++;
        if (Q_A !== 32'd0) begin
            errors++; $display("FAIL gr0_data: got %h expected 00000000", Q_A);
        end
        idle();
        ID_VALID = 1'b1; ID_LOAD = 1'b1; ID_WE = 1'b1; ID_RD = 5'd9;
        tick();
        ID_LOAD = 1'b0; ID_WE = 1'b0; RB = 5'd9; ID_USE_B = 1'b0;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL unused_no_stall: got %b expected 0", Stall);
        end
        tick();
        checks++;
        if (Q_VALID !== 1'b1) begin
            errors++; $display("FAIL unused_latch: got V=%b expected 1", Q_VALID);
        end
    endtask

    task automatic test_invalid_capture();
        idle();
        ID_VALID = 1'b0; ID_WE = 1'b1; ID_LOAD = 1'b1; ID_RD = 5'd6;
        RA = 5'd2; PA = 32'h55;
        tick();
        checks++;
        if (Q_A !== 32'h55 || Q_WE !== 1'b0 || Q_LOAD !== 1'b0 || Q_VALID !== 1'b0 || Q_RD !== 5'd0) begin
            errors++;
            $display("FAIL invalid_capture: got A=%h WE=%b LD=%b V=%b RD=%0d expected 00000055 0 0 0 0",
                     Q_A, Q_WE, Q_LOAD, Q_VALID, Q_RD);
        end
    endtask

    task automatic test_flush_vs_stall();
        idle();
        ID_VALID = 1'b1; ID_LOAD = 1'b1; ID_WE = 1'b1; ID_RD = 5'd9;
        tick();
        ID_LOAD = 1'b0; RB = 5'd9; ID_USE_B = 1'b1; Flush = 1'b1;
        #1;
        checks++;
        if (Stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %b expected 0", Stall);
        end
        tick();
        checks++;
        if (Q_VALID !== 1'b0 || Q_WE !== 1'b0) begin
            errors++; $display("FAIL flush_bubble: got V=%b WE=%b expected 0 0", Q_VALID, Q_WE);
        end
        Flush = 1'b0; ID_LOAD = 1'b1; RB = 5'd0; ID_USE_B = 1'b0;
        tick();
        ID_LOAD = 1'b0; RB = 5'd9; ID_USE_B = 1'b1; PA = 32'h77; RA = 5'd1;
        #1;
        checks++;
        if (Stall !== 1'b1) begin
            errors++; $display("FAIL rst_mid_stall_pre: got %b expected 1", Stall);
        end
        Rst_n = 1'b0;
        tick();
        Rst_n = 1'b1; ID_VALID = 1'b0;
        #1;
        checks++;
        if (Q_VALID !== 1'b0 || Q_RD !== 5'd0 || Q_A !== 32'd0 || Q_LOAD !== 1'b0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stall: got V=%b RD=%0d A=%h LD=%b Stall=%b expected all 0",
                     Q_VALID, Q_RD, Q_A, Q_LOAD, Stall);
        end
    endtask

    initial begin
        idle();
        Rst_n = 1'b0;
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_gr0_and_unused();
        test_invalid_capture();
        test_flush_vs_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
